// File: rtl/lock_mem_requester.sv
// Core-side requester for the lock-protected shared memory: arbitrates for the lock,
// runs LOAD/STORE/FETCH-ADD/SWAP against the shared port and restarts when preempted.
module lock_mem_requester #(
   parameter int ADDR_W      = 6,
   parameter int DATA_W      = 32,
   parameter int ARB_LATENCY = 1,
   parameter int MAX_WAIT    = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              need_lock,
   input  logic              lock,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_q
);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT_GRANT, S_READ, S_READ_WAIT, S_WRITE, S_RELEASE
   } state_t;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00, OP_STORE = 2'b01, OP_ADD = 2'b10, OP_SWAP = 2'b11
   } op_t;

   localparam logic [31:0] ARB_LAST  = 32'(ARB_LATENCY - 1);
   localparam logic [31:0] WAIT_LAST = 32'(MAX_WAIT - 1);

   state_t            state, next;
   op_t               op_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] old_q;
   logic              err_q;
   logic [31:0]       arb_cnt;
   logic [31:0]       wait_cnt;

   always_comb begin
      next = state;
      case (state)
         S_IDLE:       if (req_valid) next = S_REQ;
         S_REQ:        if (arb_cnt == ARB_LAST) next = S_WAIT_GRANT;
         S_WAIT_GRANT: begin
            if (!lock)
               next = (op_q == OP_STORE) ? S_WRITE : S_READ;
            else if (MAX_WAIT != 0 && wait_cnt == WAIT_LAST)
               next = S_RELEASE;
         end
         S_READ:       next = lock ? S_WAIT_GRANT : S_READ_WAIT;
         S_READ_WAIT:  next = lock ? S_WAIT_GRANT :
                              ((op_q == OP_LOAD) ? S_RELEASE : S_WRITE);
         S_WRITE:      next = lock ? S_WAIT_GRANT : S_RELEASE;
         S_RELEASE:    next = S_IDLE;
         default:      next = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state == S_IDLE);
      need_lock  = (state == S_REQ) || (state == S_WAIT_GRANT) || (state == S_READ) ||
                   (state == S_READ_WAIT) || (state == S_WRITE);
      mem_wren   = (state == S_WRITE) && !lock;
      resp_valid = (state == S_RELEASE);
      resp_err   = (state == S_RELEASE) && err_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         op_q        <= OP_LOAD;
         wdata_q     <= '0;
         old_q       <= '0;
         err_q       <= 1'b0;
         arb_cnt     <= '0;
         wait_cnt    <= '0;
         mem_address <= '0;
         mem_data    <= '0;
         resp_rdata  <= '0;
      end else begin
         state <= next;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  op_q        <= op_t'(req_op);
                  wdata_q     <= req_wdata;
                  mem_address <= req_addr;
                  err_q       <= 1'b0;
                  arb_cnt     <= '0;
               end
            end
            S_REQ: begin
               arb_cnt <= arb_cnt + 32'd1;
               if (next == S_WAIT_GRANT) wait_cnt <= '0;
            end
            S_WAIT_GRANT: begin
               if (lock) wait_cnt <= wait_cnt + 32'd1;
               if (next == S_WRITE) mem_data <= wdata_q;
               if (next == S_RELEASE) begin
                  err_q      <= 1'b1;
                  resp_rdata <= '0;
               end
            end
            S_READ_WAIT: begin
               // The captured value is only trusted when the lock was still ours.
               if (!lock) begin
                  old_q <= mem_q;
                  if (next == S_WRITE)
                     mem_data <= (op_q == OP_ADD) ? mem_q + wdata_q : wdata_q;
                  if (next == S_RELEASE)
                     resp_rdata <= mem_q;
               end
            end
            S_WRITE: begin
               if (next == S_RELEASE)
                  resp_rdata <= (op_q == OP_STORE) ? '0 : old_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lock_mem_requester.sv
// Directed bench for lock_mem_requester: table of uncontended transactions plus
// hand-written lock stall, preemption, timeout and mid-write reset sequences.
module tb_lock_mem_requester;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [1:0]  req_op;
   logic [5:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid, resp_err, need_lock, lock, mem_wren;
   logic [31:0] resp_rdata, mem_data, mem_q;
   logic [5:0]  mem_address;

   logic        w_req_valid, w_req_ready;
   logic [1:0]  w_req_op;
   logic [5:0]  w_req_addr;
   logic [31:0] w_req_wdata;
   logic        w_resp_valid, w_resp_err, w_need_lock, w_lock, w_mem_wren;
   logic [31:0] w_resp_rdata, w_mem_data, w_mem_q;
   logic [5:0]  w_mem_address;

   logic        ext_we;
   logic [5:0]  ext_addr;
   logic [31:0] ext_data;
   logic [31:0] mem [64];

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   lock_mem_requester dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .need_lock(need_lock), .lock(lock), .mem_address(mem_address),
      .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
   );

   lock_mem_requester #(.MAX_WAIT(4)) dut_w (
      .clk(clk), .rst(rst), .req_valid(w_req_valid), .req_ready(w_req_ready),
      .req_op(w_req_op), .req_addr(w_req_addr), .req_wdata(w_req_wdata),
      .resp_valid(w_resp_valid), .resp_rdata(w_resp_rdata), .resp_err(w_resp_err),
      .need_lock(w_need_lock), .lock(w_lock), .mem_address(w_mem_address),
      .mem_data(w_mem_data), .mem_wren(w_mem_wren), .mem_q(w_mem_q)
   );

   // Shared memory: registered read, plus a second write port standing in for the other core.
   always @(posedge clk) begin
      if (mem_wren) mem[mem_address] <= mem_data;
      if (ext_we) mem[ext_addr] <= ext_data;
      mem_q <= mem[mem_address];
   end

   typedef struct {
      logic [1:0]  op;
      logic [5:0]  addr;
      logic [31:0] wdata;
      logic [31:0] init;
      logic [31:0] exp_rdata;
      logic [31:0] exp_mem;
      int          exp_lat;
      int          exp_wren;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic poke(input logic [5:0] a, input logic [31:0] d);
      @(negedge clk);
      ext_we = 1'b1; ext_addr = a; ext_data = d;
      @(negedge clk);
      ext_we = 1'b0;
   endtask

   task automatic run_txn(input logic [1:0] op, input logic [5:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int wrens, output int bad_ready, output int bad_addr,
                          output logic nl_prev, output logic nl_resp);
      logic prev;
      lat = -1; rdata = '0; err = 1'b0; wrens = 0; bad_addr = 0;
      nl_prev = 1'b0; nl_resp = 1'b1;
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
      bad_ready = req_ready ? 0 : 1;
      @(posedge clk);
      @(negedge clk);
      // Keep req_valid high while busy and scramble the payload: both must be ignored.
      req_op = ~op; req_addr = ~addr; req_wdata = ~wdata;
      if (req_ready) bad_ready++;
      prev = need_lock;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (resp_valid) begin
            lat = i; rdata = resp_rdata; err = resp_err;
            nl_resp = need_lock; nl_prev = prev;
            break;
         end
         if (req_ready) bad_ready++;
         if (mem_wren) begin
            wrens++;
            if (mem_address !== addr) bad_addr++;
         end
         prev = need_lock;
      end
      req_valid = 1'b0;
   endtask

   task automatic txn_checks(input string tag, input logic [5:0] addr, input int lat,
                             input logic [31:0] rdata, input logic err, input int wrens,
                             input int bad_ready, input int bad_addr, input logic nl_prev,
                             input logic nl_resp, input int exp_lat, input logic [31:0] exp_rdata,
                             input logic [31:0] exp_mem, input int exp_wren);
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " rdata"}, rdata, exp_rdata);
      check({tag, " err"}, 32'(err), 32'd0);
      check({tag, " wren cycles"}, 32'(wrens), 32'(exp_wren));
      check({tag, " wren addr"}, 32'(bad_addr), 32'd0);
      check({tag, " ready while busy"}, 32'(bad_ready), 32'd0);
      check({tag, " need_lock before resp"}, 32'(nl_prev), 32'd1);
      check({tag, " need_lock in resp"}, 32'(nl_resp), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check({tag, " resp one cycle"}, 32'(resp_valid), 32'd0);
      check({tag, " need_lock idle"}, 32'(need_lock), 32'd0);
      check({tag, " ready idle"}, 32'(req_ready), 32'd1);
      check({tag, " mem"}, mem[addr], exp_mem);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, wrens, bad_ready, bad_addr;
      logic [31:0] rdata;
      logic err, nl_prev, nl_resp;

      // op, addr, wdata, initial mem, expected rdata, expected mem, latency, write cycles
      vecs[0] = '{2'b01, 6'd5,  32'h0000_00AB, 32'h7,         32'h0,         32'h0000_00AB, 3, 1};
      vecs[1] = '{2'b10, 6'd9,  32'h5,         32'h10,        32'h10,        32'h15,        5, 1};
      vecs[2] = '{2'b10, 6'd3,  32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         5, 1};
      vecs[3] = '{2'b00, 6'd12, 32'h99,        32'hDEAD,      32'hDEAD,      32'hDEAD,      4, 0};
      vecs[4] = '{2'b11, 6'd20, 32'hCAFE,      32'h1234,      32'h1234,      32'hCAFE,      5, 1};
      vecs[5] = '{2'b10, 6'd63, 32'hFFFF_FFFF, 32'h0,         32'h0,         32'hFFFF_FFFF, 5, 1};
      vecs[6] = '{2'b00, 6'd0,  32'h0,         32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 4, 0};

      rst = 1'b1; lock = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
      ext_we = 1'b0; ext_addr = '0; ext_data = '0;
      w_req_valid = 1'b0; w_req_op = '0; w_req_addr = '0; w_req_wdata = '0;
      w_lock = 1'b1; w_mem_q = '0;
      repeat (3) @(negedge clk);
      check("reset need_lock", 32'(need_lock), 32'd0);
      check("reset mem_wren", 32'(mem_wren), 32'd0);
      check("reset resp_valid", 32'(resp_valid), 32'd0);
      check("reset resp_err", 32'(resp_err), 32'd0);
      check("reset resp_rdata", resp_rdata, 32'd0);
      check("reset mem_address", 32'(mem_address), 32'd0);
      check("reset mem_data", mem_data, 32'd0);
      check("reset req_ready", 32'(req_ready), 32'd1);
      rst = 1'b0;

      for (int v = 0; v < 7; v++) begin
         poke(vecs[v].addr, vecs[v].init);
         run_txn(vecs[v].op, vecs[v].addr, vecs[v].wdata, lat, rdata, err, wrens,
                 bad_ready, bad_addr, nl_prev, nl_resp);
         txn_checks($sformatf("vec%0d", v), vecs[v].addr, lat, rdata, err, wrens, bad_ready,
                    bad_addr, nl_prev, nl_resp, vecs[v].exp_lat, vecs[v].exp_rdata,
                    vecs[v].exp_mem, vecs[v].exp_wren);
      end

      // SWAP stalled: lock rises mid-cycle 0 (with need_lock) and falls mid-cycle 10, so
      // WAIT_GRANT holds until edge 11 and the response lands at edge 14 instead of 5.
      poke(6'd2, 32'h33);
      fork
         run_txn(2'b11, 6'd2, 32'h55, lat, rdata, err, wrens, bad_ready, bad_addr, nl_prev, nl_resp);
         begin
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               if (need_lock) break;
            end
            lock = 1'b1;
            for (int i = 0; i < 10; i++) begin
               @(negedge clk);
               check("stall no wren under lock", 32'(mem_wren), 32'd0);
            end
            lock = 1'b0;
         end
      join
      txn_checks("stall swap", 6'd2, lat, rdata, err, wrens, bad_ready, bad_addr, nl_prev,
                 nl_resp, 14, 32'h33, 32'h55, 1);

      // FETCH-ADD preempted in READ_WAIT (cycle 3) while the other core writes 100:
      // restart at edge 5 gives READ 5, READ_WAIT 6, WRITE 7, response at edge 8.
      poke(6'd7, 32'd50);
      fork
         run_txn(2'b10, 6'd7, 32'd1, lat, rdata, err, wrens, bad_ready, bad_addr, nl_prev, nl_resp);
         begin
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               if (need_lock) break;
            end
            repeat (3) @(negedge clk);
            lock = 1'b1; ext_we = 1'b1; ext_addr = 6'd7; ext_data = 32'd100;
            @(negedge clk);
            lock = 1'b0; ext_we = 1'b0;
         end
      join
      txn_checks("preempt add", 6'd7, lat, rdata, err, wrens, bad_ready, bad_addr, nl_prev,
                 nl_resp, 8, 32'd100, 32'd101, 1);

      // MAX_WAIT=4 instance with lock stuck high: four WAIT_GRANT cycles, then error at edge 5.
      begin
         int n = -1;
         int w_wrens = 0;
         @(negedge clk);
         w_req_valid = 1'b1; w_req_op = 2'b10; w_req_addr = 6'd1; w_req_wdata = 32'd9;
         check("timeout ready", 32'(w_req_ready), 32'd1);
         @(posedge clk);
         @(negedge clk);
         w_req_valid = 1'b0;
         for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (w_mem_wren) w_wrens++;
            if (w_resp_valid) begin
               n = i;
               break;
            end
         end
         check("timeout latency", 32'(n), 32'd5);
         check("timeout err", 32'(w_resp_err), 32'd1);
         check("timeout rdata", w_resp_rdata, 32'd0);
         check("timeout need_lock", 32'(w_need_lock), 32'd0);
         check("timeout wren", 32'(w_wrens), 32'd0);
         @(posedge clk);
         @(negedge clk);
         check("timeout resp one cycle", 32'(w_resp_valid), 32'd0);
         check("timeout need_lock idle", 32'(w_need_lock), 32'd0);
      end

      // Reset asserted while a STORE sits in WRITE (cycle 2).
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b01; req_addr = 6'd4; req_wdata = 32'h77;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("pre-reset in write", 32'(mem_wren), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("mid-reset need_lock", 32'(need_lock), 32'd0);
      check("mid-reset mem_wren", 32'(mem_wren), 32'd0);
      check("mid-reset resp_valid", 32'(resp_valid), 32'd0);
      check("mid-reset resp_err", 32'(resp_err), 32'd0);
      check("mid-reset resp_rdata", resp_rdata, 32'd0);
      check("mid-reset mem_address", 32'(mem_address), 32'd0);
      check("mid-reset mem_data", mem_data, 32'd0);
      check("mid-reset idle", 32'(req_ready), 32'd1);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("post-reset no resp", 32'(resp_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
